fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 The block SHALL have parameter MEM_WORDS, default 37: number of valid 32-bit words in instruction memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_pc  output  32  byte address presented to instruction memory; equals internal PC register.
REQ-006 imem_instr  input  32  instruction word returned combinationally for imem_pc in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; flushes buffered instructions.
REQ-008 redirect_pc  input  32  target byte address, sampled when redirect_valid=1.
REQ-009 halt  input  1  level; stops new fetches while high.
REQ-010 if_valid  output  1  if_instr/if_pc hold a valid instruction for decode.
REQ-011 if_ready  input  1  decode accepts; transfer when if_valid && if_ready.
REQ-012 if_instr  output  32  instruction at head of buffer.
REQ-013 if_pc  output  32  byte address of if_instr.
REQ-014 fault  output  1  sticky; fetch address misaligned or beyond MEM_WORDS.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instr} pairs; if_valid/if_instr/if_pc SHALL come from the FIFO head register (no combinational path from imem_instr).
REQ-016 States SHALL be FETCH, HALTED, FAULT; reset enters FETCH.
REQ-017 In FETCH, enqueue SHALL occur when (count<2) or (count==2 and dequeue this cycle), halt=0, redirect_valid=0 and PC is legal; on enqueue {PC, imem_instr} is written and PC <= PC+4.
REQ-018 PC SHALL be legal iff PC[1:0]==0 and PC[31:2] < MEM_WORDS; an illegal PC in FETCH with enqueue otherwise permitted SHALL move to FAULT without enqueue and set fault=1.
REQ-019 Dequeue SHALL occur when if_valid && if_ready; simultaneous enqueue and dequeue SHALL keep count unchanged and preserve order.
REQ-020 redirect_valid=1 (any state except FAULT) SHALL flush the FIFO (count=0, if_valid=0 next cycle), load PC <= redirect_pc, suppress enqueue that cycle, and enter FETCH; a concurrent dequeue is discarded by the flush.
REQ-021 redirect_pc with bits[1:0]!=0 SHALL be loaded, then trigger FAULT on the next fetch attempt per REQ-018.
REQ-022 halt=1 in FETCH without redirect SHALL enter HALTED; HALTED SHALL not enqueue, SHALL continue dequeuing, and SHALL return to FETCH when halt=0.
REQ-023 Priority SHALL be reset > redirect_valid > halt > fetch.
REQ-024 FAULT SHALL be left only by reset; redirect_valid and halt are ignored; remaining FIFO entries still drain.
REQ-025 Latency: instruction enqueued at edge N SHALL appear with if_valid=1 after edge N; sustained throughput one instruction/cycle with if_ready held high.
REQ-026 PC+4 SHALL wrap modulo 2^32; wrap is caught by the MEM_WORDS legality check.

Reset
REQ-027 On reset: PC=RESET_PC, state=FETCH, count=0, if_valid=0, if_instr=0, if_pc=0, fault=0; imem_pc=RESET_PC in the following cycle.
REQ-028 Reset asserted mid-operation SHALL discard FIFO contents and any pending redirect in that cycle.

Structure
REQ-029 Package fetch_pkg SHALL hold the state encoding, a RESET_PC default and a MEM_WORDS default constant.
REQ-030 The FIFO SHALL be a sub-module fetch_fifo2 (2-deep, 64-bit entries, push/pop/flush, count output).

Verification
REQ-031 Reset release, if_ready=1, memory words 0..3 = 32'h00011020, 32'h00832383, 32'h0064A423, 32'h00B62423 -> if_pc 0,4,8,12 on consecutive cycles, first if_valid one edge after first fetch.
REQ-032 if_ready=0 for 5 cycles -> count stops at 2, imem_pc holds 32'h8, no instruction lost or duplicated on release.
REQ-033 redirect_valid=1, redirect_pc=32'h10 while count=2 -> if_valid=0 next cycle, then if_pc=32'h10, if_instr=mem[4].
REQ-034 PC reaches 32'h94 (word 37) -> fault=1, state FAULT, words 35 and 36 still delivered, later redirect to 32'h0 ignored until reset.
REQ-035 redirect_pc=32'h6 -> fault=1 on next cycle, no enqueue of address 6.
REQ-036 halt=1 for 3 cycles with if_ready=1 -> FIFO drains, no new fetches, imem_pc frozen; halt=0 resumes at frozen PC; halt and redirect_valid same cycle -> redirect wins.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// Holds the controller state encoding and the fetch address legality rule.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS_DEFAULT = 37;

    function automatic logic pc_legal(input logic [31:0] pc,
                                      input int unsigned words);
        return (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < words);
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, instr} queue with a registered head entry.
// Flush wins over push and pop; push into a full queue needs a pop in the same cycle.
module fetch_fifo2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [63:0] data_i,
    output logic [63:0] head_o,
    output logic        valid_o,
    output logic [1:0]  count_o
);

    logic [63:0] head_q, head_d;
    logic [63:0] tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic        pop, push;

    assign pop  = pop_i && (count_q != 2'd0);
    assign push = push_i && ((count_q != 2'd2) || pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = data_i;
                    else                 tail_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Order is kept: the new word goes behind whatever remains.
                    if (count_q == 2'd1) begin
                        head_d = data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: PC sequencing, redirect, halt and fault handling.
// Decode sees only the registered FIFO head, never imem_instr directly.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        push, flush, deq, room;
    logic [1:0]  count;
    logic [63:0] head;

    assign deq  = if_valid && if_ready;
    assign room = (count != 2'd2) || deq;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else if (halt) begin
                    state_d = ST_HALTED;
                end else if (room) begin
                    if (pc_legal(pc_q, MEM_WORDS)) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            // Only reset leaves FAULT; the queue keeps draining.
            ST_FAULT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (deq),
        .flush_i (flush),
        .data_i  ({pc_q, imem_instr}),
        .head_o  (head),
        .valid_o (if_valid),
        .count_o (count)
    );

    assign imem_pc  = pc_q;
    assign if_pc    = head[63:32];
    assign if_instr = head[31:0];
    assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based reference model.
// Directed scenarios first, then a randomized run with occasional resets.
module tb_fetch_controller;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];
    logic [63:0] mq[$];
    logic [31:0] mpc;
    int          ms;

    fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(37)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a[31:2] < 30'd37) return mem[a[7:2]];
        return 32'hBAD0_BAD0;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'd37);
    endfunction

    assign imem_instr = rd(imem_pc);

    // Model: ms 0 = fetching, 1 = halted, 2 = faulted.
    task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                        input logic h, input logic rdy);
        bit deq, room;
        reset = r;
        redirect_valid = rv;
        redirect_pc = rp;
        halt = h;
        if_ready = rdy;
        if (r) begin
            mq.delete();
            mpc = 32'h0;
            ms = 0;
        end else if (ms != 2 && rv) begin
            mq.delete();
            mpc = rp;
            ms = 0;
        end else begin
            deq = (mq.size() != 0) && rdy;
            room = (mq.size() < 2) || deq;
            if (deq) mq.delete(0);
            if (ms == 0) begin
                if (h) ms = 1;
                else if (room) begin
                    if (legal(mpc)) begin
                        mq.push_back({mpc, rd(mpc)});
                        mpc = mpc + 32'd4;
                    end else begin
                        ms = 2;
                    end
                end
            end else if (ms == 1 && !h) begin
                ms = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got %b want 0", if_valid);
        end
        checks++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
            errors++; $display("FAIL rst_head got %h/%h want 0/0", if_pc, if_instr);
        end
        checks++;
        if (fault !== 1'b0 || imem_pc !== 32'h0) begin
            errors++; $display("FAIL rst_pc got pc %h fault %b want 0 0", imem_pc, fault);
        end
    endtask

    task automatic test_stream();
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== mem[i]) begin
                errors++;
                $display("FAIL stream[%0d] got v%b %h %h want v1 %h %h",
                         i, if_valid, if_pc, if_instr, 32'(i * 4), mem[i]);
            end
        end
    endtask

    task automatic test_stall();
        int seen;
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
                errors++; $display("FAIL stall_head[%0d] got v%b %h want v1 0", i, if_valid, if_pc);
            end
        end
        checks++;
        if (imem_pc !== 32'h8) begin
            errors++; $display("FAIL stall_pc got %h want 00000008", imem_pc);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(seen * 4) || if_instr !== mem[seen]) begin
                errors++;
                $display("FAIL stall_drain[%0d] got %h want %h", i, if_pc, 32'(seen * 4));
            end
            seen++;
            step(0, 0, 0, 0, 1);
        end
    endtask

    task automatic test_redirect();
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h10, 0, 0);
        checks++;
        if (if_valid !== 1'b0 || imem_pc !== 32'h10) begin
            errors++; $display("FAIL redir_flush got v%b pc %h want v0 00000010", if_valid, imem_pc);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_instr !== mem[4]) begin
            errors++; $display("FAIL redir_target got v%b %h %h want v1 00000010 %h",
                               if_valid, if_pc, if_instr, mem[4]);
        end
    endtask

    task automatic test_fault_end();
        logic [31:0] got[$];
        step(1, 0, 0, 0, 1);
        step(0, 1, 32'h8C, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1);
            if (if_valid) got.push_back(if_pc);
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h8C || got[1] !== 32'h90) begin
            errors++; $display("FAIL end_words got %0d entries want 8c,90", got.size());
        end
        checks++;
        if (fault !== 1'b1 || imem_pc !== 32'h94) begin
            errors++; $display("FAIL end_fault got f%b pc %h want f1 00000094", fault, imem_pc);
        end
        step(0, 1, 32'h0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (fault !== 1'b1 || imem_pc !== 32'h94 || if_valid !== 1'b0) begin
            errors++; $display("FAIL end_sticky got f%b pc %h v%b want f1 00000094 v0",
                               fault, imem_pc, if_valid);
        end
        step(1, 0, 0, 0, 1);
        checks++;
        if (fault !== 1'b0 || imem_pc !== 32'h0) begin
            errors++; $display("FAIL end_reset got f%b pc %h want f0 0", fault, imem_pc);
        end
    endtask

    task automatic test_misalign();
        step(1, 0, 0, 0, 1);
        step(0, 1, 32'h6, 0, 1);
        checks++;
        if (fault !== 1'b0 || imem_pc !== 32'h6) begin
            errors++; $display("FAIL mis_load got f%b pc %h want f0 00000006", fault, imem_pc);
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (fault !== 1'b1 || if_valid !== 1'b0) begin
            errors++; $display("FAIL mis_fault got f%b v%b want f1 v0", fault, if_valid);
        end
    endtask

    task automatic test_halt();
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            checks++;
            if (if_valid !== 1'b0 || imem_pc !== 32'hC) begin
                errors++; $display("FAIL halt_frozen[%0d] got v%b pc %h want v0 0000000c",
                                   i, if_valid, imem_pc);
            end
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== mem[3]) begin
            errors++; $display("FAIL halt_resume got v%b %h want v1 0000000c", if_valid, if_pc);
        end
        step(0, 1, 32'h20, 1, 1);
        step(0, 0, 0, 0, 1);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h20 || if_instr !== mem[8]) begin
            errors++; $display("FAIL halt_redir got v%b %h want v1 00000020", if_valid, if_pc);
        end
    endtask

    task automatic test_random();
        logic        r, rv, h, rdy;
        logic [31:0] rp;
        step(1, 0, 0, 0, 1);
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom % 40) == 0;
            rv  = ($urandom % 8) == 0;
            rp  = 32'($urandom_range(0, 39)) * 32'd4;
            if (($urandom % 8) == 0) rp = rp + 32'($urandom_range(1, 3));
            h   = ($urandom % 6) == 0;
            rdy = ($urandom % 4) != 0;
            step(r, rv, rp, h, rdy);
            checks++;
            if (if_valid !== (mq.size() != 0)) begin
                errors++; $display("FAIL rnd_valid[%0d] got %b want %b", n, if_valid, mq.size() != 0);
            end
            if (mq.size() != 0) begin
                checks++;
                if ({if_pc, if_instr} !== mq[0]) begin
                    errors++; $display("FAIL rnd_head[%0d] got %h %h want %h", n, if_pc, if_instr, mq[0]);
                end
            end
            checks++;
            if (fault !== (ms == 2) || imem_pc !== mpc) begin
                errors++; $display("FAIL rnd_pc[%0d] got f%b %h want f%b %h",
                                   n, fault, imem_pc, ms == 2, mpc);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        halt = 1'b0;
        if_ready = 1'b0;
        mpc = 32'h0;
        ms = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00011020;
        mem[1] = 32'h00832383;
        mem[2] = 32'h0064A423;
        mem[3] = 32'h00B62423;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_fault_end();
        test_misalign();
        test_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
